apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

APB initiator that turns a single-outstanding command handshake into APB3 transfers toward the peripheral slaves on the APB bus, such as the sleep and event units. It runs the SETUP/ACCESS phases and honours PREADY wait states. It captures PRDATA/PSLVERR and returns them on a response handshake. A wait-state timeout aborts transfers to slaves that never assert PREADY.

## Interface
- APB_ADDR_WIDTH, 12, width of PADDR and req_addr_i
- TIMEOUT_CYCLES, 16, max ACCESS cycles with PREADY low before abort; 0 disables timeout
- HCLK  in  1  clock, all state on rising edge
- HRESET  in  1  reset, asynchronous, active-high
- req_valid_i  in  1  command valid
- req_ready_o  out  1  command accepted when valid&ready at rising edge
- req_write_i  in  1  1 = write, 0 = read
- req_addr_i  in  APB_ADDR_WIDTH  byte address
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready at rising edge
- rsp_rdata_o  out  32  read data (0 for writes and timeouts)
- rsp_err_o  out  1  PSLVERR sampled at completion, or 1 on timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- busy_o  out  1  state != IDLE
- PADDR  out  APB_ADDR_WIDTH; PWDATA  out  32; PWRITE  out  1; PSEL  out  1; PENABLE  out  1
- PRDATA  in  32; PREADY  in  1; PSLVERR  in  1

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP; reset state IDLE.
- IDLE: req_ready_o=1. On req_valid_i, go to SETUP and register the command:
  - PADDR <= req_addr_i, PWRITE <= req_write_i.
  - PWDATA <= req_wdata_i for writes, 0 for reads.
- SETUP: PSEL=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: completion. Capture rsp_err_o <= PSLVERR, rsp_timeout_o <= 0, rsp_rdata_o <= PWRITE ? 0 : PRDATA. Go to RESP.
  - PREADY=0: increment wait counter (cleared on SETUP entry).
  - If TIMEOUT_CYCLES != 0 and PREADY=0 in the TIMEOUT_CYCLES-th ACCESS cycle: abort. Capture rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0. Go to RESP.
- RESP: PSEL=PENABLE=0, rsp_valid_o=1; response fields held stable. On rsp_ready_i go to IDLE.
- PADDR/PWRITE/PWDATA are stable from SETUP through the last ACCESS cycle. They keep their last values in RESP/IDLE.
- Wait counter width is $clog2(TIMEOUT_CYCLES+1) (minimum 1) and never wraps. It saturates at abort.
- PRDATA/PSLVERR are ignored outside the completing ACCESS cycle.

## Timing
- Reset values while HRESET=1:
  - state IDLE, so req_ready_o=1.
  - PSEL, PENABLE, PWRITE, rsp_valid_o, rsp_err_o, rsp_timeout_o, busy_o = 0.
  - PADDR, PWDATA, rsp_rdata_o = 0.
- Reset mid-transfer: PSEL/PENABLE drop asynchronously and the pending response is discarded.
- Command accepted at edge T:
  - SETUP during cycle T..T+1.
  - ACCESS from T+1.
  - Zero-wait slave: completion sampled at edge T+2; rsp_valid_o=1 from T+2.
- Each PREADY wait state adds one cycle.
- rsp_valid_o is never asserted in the same cycle as PSEL.
- Response accepted at edge R: IDLE from R; req_ready_o=1 in cycle R..R+1.
- Back-to-back commands with rsp_ready_i tied high: 4 cycles per zero-wait transfer.
- req_ready_o is 0 in SETUP, ACCESS and RESP. Commands are not buffered.
- Timeout abort: PSEL=PENABLE=1 for exactly TIMEOUT_CYCLES ACCESS cycles, then rsp_valid_o the next cycle.
- A PREADY arriving in the same cycle as the timeout threshold is a normal completion, not a timeout.

## Test plan
- Write 0x004 data 0x00000001, PREADY tied 1 -> SETUP 1 cycle, ACCESS 1 cycle, PADDR=0x004, PWDATA=0x1, PWRITE=1; rsp_valid 2 cycles after accept, rsp_err=0, rsp_rdata=0.
- Read 0x008, slave inserts 3 wait states then PRDATA=0xDEADBEEF, PSLVERR=1 -> PENABLE high 4 cycles with PADDR stable; rsp_rdata=0xDEADBEEF, rsp_err=1, rsp_timeout=0.
- TIMEOUT_CYCLES=16, PREADY stuck 0 -> PENABLE high exactly 16 cycles then PSEL=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- PREADY rises in the 16th ACCESS cycle with TIMEOUT_CYCLES=16 -> normal completion, rsp_timeout=0.
- rsp_ready_i held low 5 cycles with a new req_valid_i pending -> rsp fields stable, req_ready_o=0, no PSEL. After rsp_ready_i, next SETUP starts 1 cycle after return to IDLE.
- HRESET pulsed during ACCESS -> PSEL/PENABLE/rsp_valid 0 immediately; a new command after reset completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// ---------------------------------------------------------------------------
// apb_cmd_master
//
// APB3 initiator. Accepts one command at a time over a valid/ready handshake,
// runs the SETUP and ACCESS phases on the APB bus, honours PREADY wait states
// and returns PRDATA/PSLVERR on a valid/ready response handshake. A slave that
// holds PREADY low for TIMEOUT_CYCLES ACCESS cycles is abandoned and the
// transfer is reported as an error with rsp_timeout_o set.
//
// Ports
//   HCLK, HRESET           clock (rising edge), async active-high reset
//   req_valid_i/ready_o    command handshake
//   req_write_i            1 = write, 0 = read
//   req_addr_i             byte address
//   req_wdata_i            write data
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (0 for writes and timeouts)
//   rsp_err_o              PSLVERR at completion, or 1 on timeout
//   rsp_timeout_o          transfer aborted by the wait-state timeout
//   busy_o                 a command is in flight (not IDLE)
//   PADDR..PENABLE         APB request signals
//   PRDATA, PREADY,PSLVERR APB completion signals
// ---------------------------------------------------------------------------
module apb_cmd_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [31:0]               req_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_err_o,
    output logic                      rsp_timeout_o,
    output logic                      busy_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // Counter value seen during the last permitted ACCESS cycle: the counter
    // holds the number of earlier wait cycles, so the N-th cycle sees N-1.
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TO_EN     = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [31:0]               rdata_q, rdata_d;
    logic                      err_q, err_d;
    logic                      tout_q, tout_d;
    logic [CNT_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic                      timeout_hit;

    // A PREADY in the threshold cycle wins over the timeout.
    assign timeout_hit = TO_EN && !PREADY && (wait_cnt_q == LAST_WAIT);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i)                state_d = SETUP;
            SETUP:                                   state_d = ACCESS;
            ACCESS:  if (PREADY || timeout_hit)      state_d = RESP;
            RESP:    if (rsp_ready_i)                state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Decoded from the registered state so PSEL/PENABLE fall together with
    // the asynchronous reset.
    always_comb begin
        req_ready_o = 1'b0;
        PSEL        = 1'b0;
        PENABLE     = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            SETUP:   PSEL = 1'b1;
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            RESP:    rsp_valid_o = 1'b1;
            default: busy_o = 1'b0;
        endcase
    end

    // ---------------- command / response datapath ----------------
    always_comb begin
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        pwrite_d   = pwrite_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        tout_d     = tout_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    paddr_d  = req_addr_i;
                    pwrite_d = req_write_i;
                    pwdata_d = req_write_i ? req_wdata_i : 32'd0;
                end
            end
            SETUP: begin
                wait_cnt_d = '0;
            end
            ACCESS: begin
                if (PREADY) begin
                    rdata_d = pwrite_q ? 32'd0 : PRDATA;
                    err_d   = PSLVERR;
                    tout_d  = 1'b0;
                end else begin
                    if (wait_cnt_q != CNT_MAX) begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                    if (timeout_hit) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        tout_d  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            paddr_q    <= '0;
            pwdata_q   <= '0;
            pwrite_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tout_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            paddr_q    <= paddr_d;
            pwdata_q   <= pwdata_d;
            pwrite_q   <= pwrite_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            tout_q     <= tout_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign PADDR         = paddr_q;
    assign PWDATA        = pwdata_q;
    assign PWRITE        = pwrite_q;
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_apb_cmd_master
//
// Bench for apb_cmd_master. The bench plays the APB slave, and for every
// command it predicts from the command alone (wait states requested, slave
// response, timeout threshold) how many ACCESS cycles must appear and what
// response must come back.
// ---------------------------------------------------------------------------
module tb_apb_cmd_master;

    localparam int AW = 12;
    localparam int TO = 16;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0] req_addr_i;
    logic [31:0]   req_wdata_i;
    logic          rsp_valid_o, rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o, rsp_timeout_o, busy_o;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE, PSEL, PENABLE;
    logic [31:0]   PRDATA;
    logic          PREADY, PSLVERR;

    int n_cmp = 0;
    int n_mis = 0;

    apb_cmd_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .busy_o(busy_o),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    // One complete command, from request to response acceptance.
    // waits  : cycles the slave keeps PREADY low before raising it
    // hold   : cycles rsp_ready_i stays low once the response is up
    // pend   : keep a further command requested while the response waits
    task automatic do_txn(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd, input logic se,
                          input int hold, input bit pend);
        logic [31:0] exp_rd;
        logic        exp_err, exp_to;
        int          exp_n, n;
        bit          done;
        logic [44:0] bus_exp;

        // Reference: timeout wins only if the slave would need more than TO cycles.
        if (TO != 0 && waits >= TO) begin
            exp_n = TO; exp_rd = 32'd0; exp_err = 1'b1; exp_to = 1'b1;
        end else begin
            exp_n = waits + 1; exp_rd = wr ? 32'd0 : rd; exp_err = se; exp_to = 1'b0;
        end
        bus_exp = {addr, wr, (wr ? wd : 32'd0)};

        chk("idle_ready", {63'd0, req_ready_o}, 64'd1);
        req_valid_i = 1'b1; req_write_i = wr; req_addr_i = addr; req_wdata_i = wd;
        step();
        req_valid_i = 1'b0; req_write_i = 1'($urandom); req_addr_i = AW'($urandom);
        req_wdata_i = $urandom;

        // SETUP
        chk("setup_ctl", {59'd0, PSEL, PENABLE, req_ready_o, busy_o, rsp_valid_o}, {59'd0, 5'b10010});
        chk("setup_bus", {19'd0, PADDR, PWRITE, PWDATA}, {19'd0, bus_exp});
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        step();

        // ACCESS phase: act as the slave
        n = 0; done = 0;
        while (!done && n < 64) begin
            if (PSEL && PENABLE) begin
                chk("acc_bus", {19'd0, PADDR, PWRITE, PWDATA}, {19'd0, bus_exp});
                chk("acc_rspv", {63'd0, rsp_valid_o | req_ready_o}, 64'd0);
                if (n >= waits) begin
                    PREADY = 1'b1; PRDATA = rd; PSLVERR = se;
                end else begin
                    PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
                end
                n++;
                step();
            end else begin
                done = 1;
            end
        end
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        chk("acc_cycles", 64'(n), 64'(exp_n));

        // RESP
        chk("rsp_ctl", {59'd0, rsp_valid_o, PSEL, PENABLE, req_ready_o, busy_o}, {59'd0, 5'b10001});
        chk("rsp_data", {31'd0, rsp_rdata_o, rsp_err_o}, {31'd0, exp_rd, exp_err});
        chk("rsp_to", {63'd0, rsp_timeout_o}, {63'd0, exp_to});
        for (int i = 0; i < hold; i++) begin
            rsp_ready_i = 1'b0;
            if (pend) begin
                req_valid_i = 1'b1; req_addr_i = AW'($urandom);
            end
            step();
            chk("hold_ctl", {60'd0, rsp_valid_o, PSEL, req_ready_o, busy_o}, {60'd0, 4'b1001});
            chk("hold_data", {30'd0, rsp_rdata_o, rsp_err_o, rsp_timeout_o}, {30'd0, exp_rd, exp_err, exp_to});
        end
        if (pend) req_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        step();
        rsp_ready_i = 1'b0;
        chk("back_idle", {60'd0, rsp_valid_o, PSEL, req_ready_o, busy_o}, {60'd0, 4'b0010});
        chk("idle_bus", {19'd0, PADDR, PWRITE, PWDATA}, {19'd0, bus_exp});
    endtask

    initial begin
        int          r, waits, hold;
        bit          pend;
        logic        wr;
        logic [31:0] d;

        HRESET = 1'b1;
        req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        rsp_ready_i = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        #1;
        chk("rst_ctl", {57'd0, req_ready_o, PSEL, PENABLE, PWRITE, rsp_valid_o, rsp_err_o, rsp_timeout_o},
            {57'd0, 7'b1000000});
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_data", {PADDR, PWDATA, 20'd0}, 64'd0);
        chk("rst_rdata", {32'd0, rsp_rdata_o}, 64'd0);
        step(); step();
        HRESET = 1'b0;
        step();

        // Directed cases
        do_txn(1'b1, 12'h004, 32'h0000_0001, 0, 32'h0, 1'b0, 0, 1'b0);
        do_txn(1'b0, 12'h008, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b1, 0, 1'b0);
        do_txn(1'b0, 12'h010, 32'h0, 100, 32'hCAFE_F00D, 1'b0, 0, 1'b0);
        do_txn(1'b0, 12'h014, 32'h0, TO - 1, 32'hA5A5_5A5A, 1'b0, 0, 1'b0);
        do_txn(1'b1, 12'h018, 32'h5555_AAAA, 1, 32'h0, 1'b0, 5, 1'b1);
        do_txn(1'b1, 12'h01C, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, 0, 1'b0);

        // Reset while in ACCESS
        req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 12'h0FC; req_wdata_i = 32'hFFFF_FFFF;
        step();
        req_valid_i = 1'b0;
        PREADY = 1'b0;
        step();
        step();
        chk("pre_rst_acc", {62'd0, PSEL, PENABLE}, 64'd3);
        #2 HRESET = 1'b1;
        #1;
        chk("mid_rst_ctl", {60'd0, PSEL, PENABLE, rsp_valid_o, req_ready_o}, {60'd0, 4'b0001});
        chk("mid_rst_data", {19'd0, PADDR, PWRITE, PWDATA}, 64'd0);
        step();
        HRESET = 1'b0;
        step();
        chk("post_rst_idle", {62'd0, rsp_valid_o, busy_o}, 64'd0);
        do_txn(1'b0, 12'h020, 32'h0, 2, 32'h1357_9BDF, 1'b0, 1, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 80; t++) begin
            wr = 1'($urandom);
            r  = int'($urandom_range(0, 9));
            if (r <= 5)      waits = int'($urandom_range(0, 3));
            else if (r <= 7) waits = int'($urandom_range(4, TO - 2));
            else if (r == 8) waits = TO - 1;
            else             waits = int'($urandom_range(TO, TO + 4));
            hold = int'($urandom_range(0, 3));
            pend = 1'($urandom);
            d = $urandom;
            do_txn(wr, AW'($urandom), $urandom, waits, d, 1'($urandom), hold, pend);
            if (!pend) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    step();
                    chk("gap_idle", {61'd0, req_ready_o, PSEL, rsp_valid_o}, {61'd0, 3'b100});
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
